// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-pipeline types: instruction/PC widths, bubble encoding, fetch FSM states.
// Holds no logic; the only helper is the PC increment used by the fetch stage and IF/ID view.
package if_fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    addr;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    // Wraps modulo 2^32, so the word after 32'hFFFFFFFC is fetched from 0.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack port; fetch side is the master, memory is the slave.
// req and addr hold until a single-cycle ack, which may land in the first req cycle.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_fetch_buffer.sv
// Circular buffer of {addr, word} fetch results; head is readable the cycle after a push.
// Push and pop may coincide; flush wins over both. The caller never pushes when full or pops when empty.
module if_fetch_stage_fetch_buffer
    import if_fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, buffers words for IF/ID.
// First word reaches IF/ID two cycles after reset release; freeze backs up the buffer, which then stops issue.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'd0,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_addr,
    if_fetch_stage_if.master   imem,
    output logic               valid_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instruction_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_addr_q, req_addr_d;

    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     head_dat;
    fetch_entry_t     push_dat;

    logic             consume;
    logic             ack_push;
    logic             can_request;
    logic             has_room;
    logic             issue;
    logic [CNT_W:0]   occ_next;

    assign consume     = valid_out & ~freeze & ~branch_taken;
    assign ack_push    = (state_q == FETCH_WAIT) & imem.imem_ack & ~branch_taken;
    assign can_request = (state_q == FETCH_IDLE) | ((state_q == FETCH_WAIT) & imem.imem_ack);

    // Issue only if the buffer still has a free slot after this edge, so the
    // response of the new request can always be pushed whenever it returns.
    assign occ_next = {1'b0, buf_count}
                    - {{CNT_W{1'b0}}, consume}
                    + {{CNT_W{1'b0}}, ack_push};
    assign has_room = occ_next < (CNT_W + 1)'(DEPTH);
    assign issue    = can_request & has_room & ~branch_taken;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (branch_taken) begin
            pc_d = branch_addr;
            // A request still in flight must have its response swallowed.
            case (state_q)
                FETCH_WAIT:    state_d = imem.imem_ack ? FETCH_IDLE : FETCH_DISCARD;
                FETCH_DISCARD: state_d = imem.imem_ack ? FETCH_IDLE : FETCH_DISCARD;
                default:       state_d = FETCH_IDLE;
            endcase
        end else begin
            case (state_q)
                FETCH_IDLE:    state_d = FETCH_IDLE;
                FETCH_WAIT:    state_d = imem.imem_ack ? FETCH_IDLE : FETCH_WAIT;
                FETCH_DISCARD: state_d = imem.imem_ack ? FETCH_IDLE : FETCH_DISCARD;
                default:       state_d = FETCH_IDLE;
            endcase
            if (issue) begin
                req_addr_d = pc_q;
                pc_d       = pc_incr(pc_q);
                state_d    = FETCH_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign push_dat = '{addr: req_addr_q, word: imem.imem_rdata};

    if_fetch_stage_fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .rst      (rst),
        .push     (ack_push),
        .push_dat (push_dat),
        .pop      (consume),
        .flush    (branch_taken),
        .head_dat (head_dat),
        .count    (buf_count)
    );

    assign imem.imem_req  = (state_q != FETCH_IDLE);
    assign imem.imem_addr = req_addr_q;

    always_comb begin
        valid_out       = (buf_count != '0);
        pc_out          = '0;
        instruction_out = NOP_INSTR;
        if (valid_out) begin
            pc_out          = pc_incr(head_dat.addr);
            instruction_out = head_dat.word;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: reactive imem model plus a queue-based reference of the fetch stage.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem            (imem),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .instruction_out (instruction_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference: next PC, one optional outstanding request (possibly doomed), queue of fetched words.
    logic [31:0] m_pc;
    logic [31:0] m_raddr;
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_qa[$];
    logic [31:0] m_qw[$];

    int lat_min   = 0;
    int lat_max   = 0;
    int mem_left  = 0;
    bit mem_fresh = 1'b1;
    bit force_ack = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic out_t observe();
        out_t o;
        o.req   = imem.imem_req;
        o.addr  = imem.imem_addr;
        o.vld   = valid_out;
        o.pc    = pc_out;
        o.instr = instruction_out;
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.req   = m_busy;
        o.addr  = m_raddr;
        o.vld   = (m_qa.size() != 0);
        o.pc    = 32'd0;
        o.instr = 32'd0;
        if (m_qa.size() != 0) begin
            o.pc    = m_qa[0] + 32'd4;
            o.instr = m_qw[0];
        end
        return o;
    endfunction

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_raddr = 32'd0;
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_qa.delete();
        m_qw.delete();
    endtask

    // One clock: memory reacts to the DUT request, inputs are driven, the model advances.
    task automatic step(input logic r, input logic f, input logic br, input logic [31:0] ba,
                        output out_t exp);
        logic        ack;
        logic [31:0] rdata;
        bit          cons;
        bit          can_issue;
        ack   = 1'b0;
        rdata = $urandom;
        if (force_ack) begin
            ack       = 1'b1;
            mem_fresh = 1'b1;
        end else if (imem.imem_req === 1'b1) begin
            if (mem_fresh) begin
                mem_left  = int'($urandom_range(lat_max, lat_min));
                mem_fresh = 1'b0;
            end
            if (mem_left == 0) begin
                ack       = 1'b1;
                rdata     = word_of(imem.imem_addr);
                mem_fresh = 1'b1;
            end else begin
                mem_left--;
            end
        end else begin
            mem_fresh = 1'b1;
        end
        if (r) mem_fresh = 1'b1;

        rst             = r;
        freeze          = f;
        branch_taken    = br;
        branch_addr     = ba;
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;

        if (r) begin
            model_reset();
        end else begin
            cons      = (m_qa.size() != 0) && !f && !br;
            can_issue = !m_busy || (ack && !m_drop);
            if (br) begin
                m_qa.delete();
                m_qw.delete();
                m_pc = ba;
                if (m_busy && ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else if (m_busy) begin
                    m_drop = 1'b1;
                end
            end else begin
                if (cons) begin
                    void'(m_qa.pop_front());
                    void'(m_qw.pop_front());
                end
                if (m_busy && ack) begin
                    if (!m_drop) begin
                        m_qa.push_back(m_raddr);
                        m_qw.push_back(rdata);
                    end
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end
                if (can_issue && m_qa.size() < DEPTH) begin
                    m_raddr = m_pc;
                    m_pc    = m_pc + 32'd4;
                    m_busy  = 1'b1;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        exp = model_out();
    endtask

    task automatic apply_reset();
        out_t exp;
        step(1'b1, 1'b0, 1'b0, 32'd0, exp);
        step(1'b1, 1'b0, 1'b0, 32'd0, exp);
    endtask

    task automatic test_reset();
        out_t obs, exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(1, 0)), 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_model @%0d: got %h, want %h", cyc, obs, exp);
            end
        end
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_zero @%0d: got %h, want 0", cyc, obs);
        end
    endtask

    task automatic test_zero_wait();
        out_t obs, exp;
        lat_min = 0;
        lat_max = 0;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL zero_wait_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            if (k == 1) begin
                n_cmp++;
                if ({obs.req, obs.addr, obs.vld} !== {1'b1, RESET_PC, 1'b0}) begin
                    n_bad++;
                    $display("FAIL zero_wait_first_req @%0d: got %h, want %h", cyc,
                             {obs.req, obs.addr, obs.vld}, {1'b1, RESET_PC, 1'b0});
                end
            end else begin
                n_cmp++;
                if ({obs.vld, obs.pc, obs.instr} !==
                    {1'b1, RESET_PC + 32'(4 * (k - 1)), word_of(RESET_PC + 32'(4 * (k - 2)))}) begin
                    n_bad++;
                    $display("FAIL zero_wait_stream @%0d: got %h, want %h", cyc,
                             {obs.vld, obs.pc, obs.instr},
                             {1'b1, RESET_PC + 32'(4 * (k - 1)), word_of(RESET_PC + 32'(4 * (k - 2)))});
                end
            end
        end
    endtask

    task automatic test_slow_mem();
        out_t obs, exp;
        bit   prev_vld;
        int   pulses;
        int   exp_pulses;
        lat_min    = 2;
        lat_max    = 2;
        prev_vld   = 1'b0;
        pulses     = 0;
        // First word at cycle lat+2, then one every lat+1 cycles.
        exp_pulses = (20 - (lat_max + 2)) / (lat_max + 1) + 1;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL slow_mem_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            n_cmp++;
            if (obs.vld && prev_vld) begin
                n_bad++;
                $display("FAIL slow_mem_gap @%0d: got back-to-back valid, want bubble", cyc);
            end
            if (obs.vld) pulses++;
            prev_vld = obs.vld;
        end
        n_cmp++;
        if (pulses != exp_pulses) begin
            n_bad++;
            $display("FAIL slow_mem_pulses: got %0d, want %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_freeze();
        out_t obs, exp;
        bit   found;
        lat_min = 0;
        lat_max = 0;
        found   = 1'b0;
        apply_reset();
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL freeze_pre_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            if (obs.vld && obs.pc == 32'd12) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL freeze_reach_12 @%0d: got pc %h, want 0000000c within 10 cycles", cyc, obs.pc);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL freeze_hold_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            n_cmp++;
            if ({obs.vld, obs.pc} !== {1'b1, 32'd12}) begin
                n_bad++;
                $display("FAIL freeze_head @%0d: got %h, want %h", cyc, {obs.vld, obs.pc}, {1'b1, 32'd12});
            end
        end
        n_cmp++;
        if (obs.req !== 1'b0) begin
            n_bad++;
            $display("FAIL freeze_req_drop @%0d: got %b, want 0", cyc, obs.req);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL freeze_release_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            n_cmp++;
            if ({obs.vld, obs.pc, obs.instr} !== {1'b1, 32'(12 + 4 * (i + 1)), word_of(32'(8 + 4 * (i + 1)))}) begin
                n_bad++;
                $display("FAIL freeze_release_seq @%0d: got %h, want %h", cyc, {obs.vld, obs.pc, obs.instr},
                         {1'b1, 32'(12 + 4 * (i + 1)), word_of(32'(8 + 4 * (i + 1)))});
            end
        end
    endtask

    task automatic test_branch_discard();
        out_t obs, exp;
        bit   found;
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        apply_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL discard_pre_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            if (obs.req && obs.addr == 32'h20) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL discard_reach_20 @%0d: got addr %h, want 00000020 within 60 cycles", cyc, obs.addr);
        end
        step(1'b0, 1'b0, 1'b1, 32'h100, exp);
        obs = observe();
        n_cmp++;
        if ({obs.req, obs.addr, obs.vld} !== {1'b1, 32'h20, 1'b0}) begin
            n_bad++;
            $display("FAIL discard_hold @%0d: got %h, want %h", cyc, {obs.req, obs.addr, obs.vld},
                     {1'b1, 32'h20, 1'b0});
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL discard_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            if (obs.vld) begin
                found = 1'b1;
                n_cmp++;
                if ({obs.pc, obs.instr} !== {32'h104, word_of(32'h100)}) begin
                    n_bad++;
                    $display("FAIL discard_target @%0d: got %h, want %h", cyc, {obs.pc, obs.instr},
                             {32'h104, word_of(32'h100)});
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL discard_timeout @%0d: got no valid, want word from 00000100", cyc);
        end
    endtask

    task automatic test_branch_freeze_full();
        out_t obs, exp;
        lat_min = 0;
        lat_max = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL full_fill_model @%0d: got %h, want %h", cyc, obs, exp);
            end
        end
        n_cmp++;
        if ({obs.req, obs.vld, obs.pc} !== {1'b0, 1'b1, RESET_PC + 32'd4}) begin
            n_bad++;
            $display("FAIL full_state @%0d: got %h, want %h", cyc, {obs.req, obs.vld, obs.pc},
                     {1'b0, 1'b1, RESET_PC + 32'd4});
        end
        step(1'b0, 1'b1, 1'b1, 32'h200, exp);
        obs = observe();
        n_cmp++;
        if ({obs.req, obs.vld, obs.pc, obs.instr} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL full_branch_flush @%0d: got %h, want 0", cyc, {obs.req, obs.vld, obs.pc, obs.instr});
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, exp);
        obs = observe();
        n_cmp++;
        if ({obs.req, obs.addr} !== {1'b1, 32'h200}) begin
            n_bad++;
            $display("FAIL full_branch_fetch @%0d: got %h, want %h", cyc, {obs.req, obs.addr}, {1'b1, 32'h200});
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, exp);
        obs = observe();
        n_cmp++;
        if ({obs.vld, obs.pc, obs.instr} !== {1'b1, 32'h204, word_of(32'h200)}) begin
            n_bad++;
            $display("FAIL full_branch_word @%0d: got %h, want %h", cyc, {obs.vld, obs.pc, obs.instr},
                     {1'b1, 32'h204, word_of(32'h200)});
        end
    endtask

    task automatic test_reset_mid();
        out_t obs, exp;
        bit   found;
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        apply_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0, exp);
        step(1'b0, 1'b0, 1'b0, 32'd0, exp);
        obs = observe();
        n_cmp++;
        if (obs.req !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_wait @%0d: got req %b, want 1", cyc, obs.req);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, exp);
        obs = observe();
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL midrst_zero @%0d: got %h, want 0", cyc, obs);
        end
        force_ack = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'd0, exp);
        force_ack = 1'b0;
        obs = observe();
        n_cmp++;
        if ({obs.req, obs.addr, obs.vld} !== {1'b1, RESET_PC, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_late_ack @%0d: got %h, want %h", cyc, {obs.req, obs.addr, obs.vld},
                     {1'b1, RESET_PC, 1'b0});
        end
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL midrst_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            if (obs.vld) begin
                found = 1'b1;
                n_cmp++;
                if ({obs.pc, obs.instr} !== {RESET_PC + 32'd4, word_of(RESET_PC)}) begin
                    n_bad++;
                    $display("FAIL midrst_first_word @%0d: got %h, want %h", cyc, {obs.pc, obs.instr},
                             {RESET_PC + 32'd4, word_of(RESET_PC)});
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL midrst_timeout @%0d: got no valid, want word from reset pc", cyc);
        end
    endtask

    task automatic test_pc_wrap();
        out_t        obs, exp;
        logic [31:0] pcs[$];
        logic [31:0] want;
        lat_min = 0;
        lat_max = 0;
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, exp);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL wrap_model @%0d: got %h, want %h", cyc, obs, exp);
            end
            if (obs.vld) pcs.push_back(obs.pc);
        end
        for (int i = 0; i < 3; i++) begin
            want = 32'hFFFF_FFF8 + 32'(4 * (i + 1));
            n_cmp++;
            if (pcs.size() <= i) begin
                n_bad++;
                $display("FAIL wrap_seq[%0d]: got no valid, want %h", i, want);
            end else if (pcs[i] !== want) begin
                n_bad++;
                $display("FAIL wrap_seq[%0d]: got %h, want %h", i, pcs[i], want);
            end
        end
    endtask

    task automatic test_random();
        out_t        obs, exp;
        logic        r, f, br;
        logic [31:0] ba;
        lat_min = 0;
        lat_max = 3;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(99, 0) == 0);
            f  = ($urandom_range(99, 0) < 30);
            br = ($urandom_range(99, 0) < 6);
            if ($urandom_range(3, 0) == 0)
                ba = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3, 0));
            else
                ba = $urandom & 32'h0000_0FFC;
            step(r, f, br, ba, exp);
            obs = observe();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL random_model @%0d: got %h, want %h", cyc, obs, exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        freeze          = 1'b0;
        branch_taken    = 1'b0;
        branch_addr     = 32'd0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'd0;
        model_reset();

        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_freeze();
        test_branch_discard();
        test_branch_freeze_full();
        test_reset_mid();
        test_pc_wrap();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
